fetch_unit: RTL and testbench

Instruction-fetch stage of the RV32I core, directly upstream of the decode/control stage. Owns the program counter, issues in-order word requests to instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a small FIFO presented to decode with valid/ready. Branch redirects from the control unit (PCSrc plus target) flush the buffer and discard any in-flight response.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the RV32I instruction-fetch stage: FSM state encoding,
// instruction size and the buffered {pc, instr} entry.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,  // no request outstanding
    WAIT = 2'd1,  // one request outstanding, response will be kept
    DROP = 2'd2,  // one request outstanding, response will be discarded
    HALT = 2'd3   // stopped on a misaligned redirect target
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch_entry_t. Flush empties it in one cycle,
// push and pop may happen together (also when full), count is the fill level.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         valid_q, valid_d;
  logic         do_push;
  logic         do_pop;

  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign valid = valid_q;

  // Next-state for storage and pointers; flush overrides push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && (count != '0);
    do_push  = push && ((count != FULL_CNT) || do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
    valid_d = (wr_ptr_d != rd_ptr_d);
  end

  // Storage, pointers and the registered head-valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage. Owns the PC, keeps at most one word request
// in flight to instruction memory and buffers responses with their PCs for
// decode. Redirects flush the buffer and squash an in-flight response.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect target
// raises sticky fetch_misalign and halts fetch until reset).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         misalign_q, misalign_d;

  logic         redirect_eff;
  logic         req_valid;
  logic         req_fire;
  logic         resp_keep;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic [AW:0]  fifo_count;

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign dec_instr      = head_entry.instr;
  assign dec_pc         = head_entry.pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_misalign = misalign_q;
`endif

  // Request/response qualification; HALT ignores redirects entirely.
  always_comb begin
    redirect_eff = redirect_valid && (state_q != HALT);
    req_valid    = !rst && (state_q == RUN) && !redirect_valid && (fifo_count < FULL_CNT);
    req_fire     = req_valid && imem_req_ready;
    resp_keep    = (state_q == WAIT) && imem_resp_valid && !redirect_eff;
    push_entry   = '{pc: req_pc_q, instr: imem_resp_data};
  end

  // FSM next state and PC update; a redirect takes priority over everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    misalign_d = misalign_q;
    if (redirect_eff) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_target[1:0] != 2'b00) begin
        state_d    = HALT;
        misalign_d = 1'b1;
      end else begin
        fetch_pc_d = redirect_target;
        state_d    = ((state_q == RUN) || imem_resp_valid) ? RUN : DROP;
      end
`else
      fetch_pc_d = {redirect_target[31:2], 2'b00};
      state_d    = ((state_q == RUN) || imem_resp_valid) ? RUN : DROP;
`endif
    end else begin
      case (state_q)
        RUN: begin
          if (req_fire) begin
            state_d    = WAIT;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
          end else begin
            state_d = RUN;
          end
        end
        WAIT, DROP: begin
          if (imem_resp_valid) begin
            state_d = RUN;
          end else begin
            state_d = state_q;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  // State, PC and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_eff),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (dec_ready),
    .head      (head_entry),
    .valid     (dec_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural memory answers accepted
// requests after a programmable latency; kept responses are queued as expected
// decode entries and compared when decode pops them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .dec_valid       (dec_valid),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .dec_ready       (dec_ready)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misalign  (fetch_misalign)
`endif
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  // model state
  logic [31:0] exp_pc;
  logic [63:0] exp_q[$];
  bit          pend;
  bit          pend_drop;
  bit          halted;
  logic [31:0] pend_addr;
  int          pend_wait;
  int          lat;
  int          req_cnt;
  bit          seen_zero;
  bit          want_first;
  logic [31:0] first_exp;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: inputs already set by the caller, memory drives its response.
  task automatic cycle();
    bit          acc;
    bit          pop;
    bit          resp;
    bit          redir_eff;
    logic [31:0] a;
    logic [63:0] e;
    imem_resp_valid = pend && (pend_wait == 0);
    imem_resp_data  = imem_resp_valid ? mem_word(pend_addr) : 32'h0;
    @(negedge clk);
    acc       = imem_req_valid && imem_req_ready;
    pop       = dec_valid && dec_ready;
    resp      = imem_resp_valid;
    a         = imem_req_addr;
    redir_eff = redirect_valid && !halted;
    check_val("req_valid", 64'(imem_req_valid),
              64'(!halted && !pend && !redirect_valid && (exp_q.size() < 2)));
    check_val("dec_valid", 64'(dec_valid), 64'(exp_q.size() != 0));
`ifdef FETCH_MISALIGN_CHECK_EN
    check_val("misalign", 64'(fetch_misalign), 64'(halted));
`endif
    if (pop && (exp_q.size() != 0)) begin
      e = exp_q.pop_front();
      check_val("dec_pc", 64'(dec_pc), 64'(e[63:32]));
      check_val("dec_instr", 64'(dec_instr), 64'(e[31:0]));
      if (want_first) begin
        check_val("redir_first_pc", 64'(dec_pc), 64'(first_exp));
        want_first = 1'b0;
      end
    end
    if (resp) begin
      if (!pend_drop && !redir_eff) exp_q.push_back({pend_addr, mem_word(pend_addr)});
      pend = 1'b0;
    end else if (pend) begin
      pend_wait--;
    end
    if (acc) begin
      check_val("req_addr", 64'(a), 64'(exp_pc));
      exp_pc = exp_pc + 32'd4;
      req_cnt++;
      if (a == 32'h0) seen_zero = 1'b1;
      pend      = 1'b1;
      pend_addr = a;
      pend_wait = lat - 1;
      pend_drop = 1'b0;
    end
    if (redir_eff) begin
      exp_q.delete();
      if (pend) pend_drop = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_target[1:0] != 2'b00) halted = 1'b1;
      else exp_pc = redirect_target;
`else
      exp_pc = {redirect_target[31:2], 2'b00};
`endif
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    dec_ready       = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    exp_q.delete();
    pend       = 1'b0;
    pend_drop  = 1'b0;
    halted     = 1'b0;
    want_first = 1'b0;
    exp_pc     = 32'h0;
    @(negedge clk);
    check_val("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check_val("rst_dec_valid", 64'(dec_valid), 64'd0);
    check_val("rst_req_addr", 64'(imem_req_addr), 64'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_val("rst_misalign", 64'(fetch_misalign), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int  base;
    bit  found;
    lat     = 1;
    req_cnt = 0;
    do_reset();

    // back-to-back fetch, 1-cycle memory, decode always ready
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    repeat (12) cycle();
    check_val("t1_req_count", 64'(req_cnt), 64'd6);

    // decode stalled: buffer fills, requests stop; one pop lets one more through
    dec_ready = 1'b0;
    repeat (10) cycle();
    base = req_cnt;
    repeat (4) cycle();
    check_val("stall_no_req", 64'(req_cnt - base), 64'd0);
    check_val("stall_full_valid", 64'(dec_valid), 64'd1);
    dec_ready = 1'b1;
    cycle();
    dec_ready = 1'b0;
    base = req_cnt;
    repeat (6) cycle();
    check_val("one_pop_one_req", 64'(req_cnt - base), 64'd1);
    dec_ready = 1'b1;
    repeat (8) cycle();

    // redirect while a request is outstanding: response dropped
    lat   = 2;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pend && (pend_wait > 0)) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check_val("t3_sync", 64'(found), 64'd1);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    want_first      = 1'b1;
    first_exp       = 32'h0000_0100;
    cycle();
    repeat (12) cycle();
    check_val("t3_target_seen", 64'(want_first), 64'd0);

    // redirect coinciding with a response and a decode pop
    lat       = 1;
    dec_ready = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pend && (pend_wait == 0) && (exp_q.size() >= 1)) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check_val("t4_sync", 64'(found), 64'd1);
    dec_ready       = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    cycle();
    check_val("t4_flushed", 64'(dec_valid), 64'd0);
    want_first = 1'b1;
    first_exp  = 32'h0000_0040;
    repeat (8) cycle();
    check_val("t4_target_seen", 64'(want_first), 64'd0);

    // PC wrap from 0xFFFF_FFFC to 0
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    seen_zero       = 1'b0;
    cycle();
    want_first = 1'b1;
    first_exp  = 32'hFFFF_FFFC;
    repeat (10) cycle();
    check_val("wrap_zero_req", 64'(seen_zero), 64'd1);
    check_val("wrap_first_pc", 64'(want_first), 64'd0);

    // misaligned redirect target
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0102;
    cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
    check_val("mis_flag", 64'(fetch_misalign), 64'd1);
    base            = req_cnt;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    cycle();
    repeat (6) cycle();
    check_val("mis_no_req", 64'(req_cnt - base), 64'd0);
    check_val("mis_sticky", 64'(fetch_misalign), 64'd1);
`else
    want_first = 1'b1;
    first_exp  = 32'h0000_0100;
    repeat (8) cycle();
    check_val("mis_forced_align", 64'(want_first), 64'd0);
`endif

    // reset mid-stream then resume
    do_reset();
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    want_first     = 1'b1;
    first_exp      = 32'h0000_0000;
    repeat (6) cycle();
    check_val("post_rst_first_pc", 64'(want_first), 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
